// File: rtl/fsm_eg_pkg.sv
// Shared definitions for the fsm_eg stimulus driver.
//   fsm_state_t  : encodings of the tutorial FSM states S0/S1/S2 (2 bits)
//   OUT_ACTIVE   : value the FSM drives on x/y when an output is active
//   ctrl_state_t : control states of the driver
//   decode_target: maps a 2-bit command target onto a state (3 -> S0)
//   steer_ab     : one-cycle {a,b} drive that moves the FSM toward a target
package fsm_eg_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } fsm_state_t;

  localparam logic [7:0] OUT_ACTIVE = 8'd168;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEER = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  function automatic fsm_state_t decode_target(input logic [1:0] t);
    case (t)
      2'd1:    return S1;
      2'd2:    return S2;
      default: return S0;
    endcase
  endfunction

  // Returns {a,b}. S1->S2 and S2->S1 both route through S0, so only the
  // first leg is produced here; the next STEER cycle picks up the second.
  function automatic logic [1:0] steer_ab(input fsm_state_t cur, input fsm_state_t tgt);
    case (cur)
      S0:      return (tgt == S2) ? 2'b11 : ((tgt == S1) ? 2'b10 : 2'b00);
      S1:      return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/fsm_eg_driver_model.sv
// Combinational reference model of the tutorial fsm_eg machine.
// Ports:
//   state      in  : current (shadow) state
//   a, b       in  : inputs applied to the machine this cycle
//   next_state out : state after the next clock edge
//   x_exp      out : expected Mealy output
//   y_exp      out : expected Moore output
module fsm_eg_model
  import fsm_eg_pkg::*;
(
  input  fsm_state_t state,
  input  logic       a,
  input  logic       b,
  output fsm_state_t next_state,
  output logic [7:0] x_exp,
  output logic [7:0] y_exp
);

  always_comb begin
    next_state = state;
    x_exp      = '0;
    y_exp      = '0;
    case (state)
      S0: begin
        if (a && b) next_state = S2;
        else if (a) next_state = S1;
      end
      S1: if (a) next_state = S0;
      default: next_state = S0;
    endcase
    if ((state == S0 || state == S2) && a && b) x_exp = OUT_ACTIVE;
    if (state == S1) y_exp = OUT_ACTIVE;
  end

endmodule

// File: rtl/fsm_eg_driver.sv
// Stimulus driver and checker for the tutorial fsm_eg machine.
// Accepts "go to state N and dwell H cycles" commands, steers the FSM via
// registered a/b, tracks a shadow copy of its state and compares x/y.
// Ports:
//   clk, rst            : clock, synchronous active-high reset (FSM gets ~rst)
//   cmd_valid/cmd_ready : command handshake
//   cmd_target, cmd_hold: target state (3 = S0) and dwell count
//   done                : one-cycle completion pulse
//   a, b                : registered drive to the FSM under test
//   x, y                : FSM outputs under check
//   err, err_cnt        : sticky mismatch flag, saturating mismatch count
// Build option: FSM_EG_DRV_CHECK_EN enables the x/y checker; when undefined
// x/y are ignored and err/err_cnt are tied to 0.
module fsm_eg_driver
  import fsm_eg_pkg::*;
#(
  parameter int unsigned HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_target,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              done,
  output logic              a,
  output logic              b,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  output logic              err,
  output logic [7:0]        err_cnt
);

  ctrl_state_t       ctrl, ctrl_next;
  fsm_state_t        shadow, shadow_next;
  fsm_state_t        target, target_next;
  logic [HOLD_W-1:0] hold_q, hold_next;
  logic [HOLD_W-1:0] cnt, cnt_next;
  logic [1:0]        ab_next;
  logic [7:0]        x_exp, y_exp;
  logic              accept;

  fsm_eg_model u_model (
    .state      (shadow),
    .a          (a),
    .b          (b),
    .next_state (shadow_next),
    .x_exp      (x_exp),
    .y_exp      (y_exp)
  );

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl   <= IDLE;
      shadow <= S0;
      target <= S0;
      hold_q <= '0;
      cnt    <= '0;
      a      <= 1'b0;
      b      <= 1'b0;
    end else begin
      ctrl   <= ctrl_next;
      shadow <= shadow_next;
      target <= target_next;
      hold_q <= hold_next;
      cnt    <= cnt_next;
      {a, b} <= ab_next;
    end
  end

  // Decisions use shadow_next (the state the FSM will hold next cycle) so
  // that a/b can be registered yet still match the state they act upon.
  always_comb begin
    ctrl_next   = ctrl;
    target_next = target;
    hold_next   = hold_q;
    cnt_next    = cnt;
    if (accept) begin
      target_next = decode_target(cmd_target);
      hold_next   = (target_next == S2) ? '0 : cmd_hold;
      if (shadow_next != target_next) begin
        ctrl_next = STEER;
      end else if (hold_next != '0) begin
        ctrl_next = DWELL;
        cnt_next  = hold_next;
      end else begin
        ctrl_next = DONE;
      end
    end else begin
      case (ctrl)
        STEER: begin
          if (shadow_next == target) begin
            if (hold_q != '0) begin
              ctrl_next = DWELL;
              cnt_next  = hold_q;
            end else begin
              ctrl_next = DONE;
            end
          end
        end
        DWELL: begin
          if (cnt == HOLD_W'(1)) ctrl_next = DONE;
          else                   cnt_next  = cnt - HOLD_W'(1);
        end
        DONE:    ctrl_next = IDLE;
        default: ;
      endcase
    end
    ab_next = (ctrl_next == STEER) ? steer_ab(shadow_next, target_next) : 2'b00;
  end

  always_comb begin
    cmd_ready = (ctrl == IDLE) || (ctrl == DONE);
    done      = (ctrl == DONE);
  end

`ifdef FSM_EG_DRV_CHECK_EN
  logic mismatch;
  assign mismatch = (x != x_exp) || (y != y_exp);

  always_ff @(posedge clk) begin
    if (rst) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (mismatch) begin
      err <= 1'b1;
      if (err_cnt != '1) err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  logic unused_check;
  assign unused_check = ^{x, y, x_exp, y_exp};
  assign err     = 1'b0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_fsm_eg_driver.sv
// Self-checking bench for fsm_eg_driver. A behavioural fsm_eg stands in for
// the machine under test; expected per-cycle {a,b,done} traces are queued at
// command acceptance and popped by a monitor on each falling edge.
module tb_fsm_eg_driver;

`ifdef FSM_EG_DRV_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_target = 2'd0;
  logic [7:0] cmd_hold = 8'd0;
  logic       cmd_ready, done, a, b, err;
  logic [7:0] x, y, err_cnt;

  int tests = 0;
  int fails = 0;
  logic [2:0] trace_q[$];

  logic       rst_n;
  logic [1:0] fsm_s;
  logic       force_y0 = 1'b0;
  logic       corrupt_x = 1'b0;

  always #5 clk = ~clk;

  fsm_eg_driver #(.HOLD_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_hold   (cmd_hold),
    .done       (done),
    .a          (a),
    .b          (b),
    .x          (x),
    .y          (y),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  // Stand-in for the tutorial FSM, with fault hooks on x and y.
  assign rst_n = ~rst;
  always @(posedge clk) begin
    if (!rst_n) fsm_s <= 2'd0;
    else case (fsm_s)
      2'd0:    fsm_s <= (a && b) ? 2'd2 : (a ? 2'd1 : 2'd0);
      2'd1:    fsm_s <= a ? 2'd0 : 2'd1;
      default: fsm_s <= 2'd0;
    endcase
  end
  assign x = ((((fsm_s == 2'd0) || (fsm_s == 2'd2)) && a && b) ? 8'd168 : 8'd0) ^ {7'd0, corrupt_x};
  assign y = ((fsm_s == 2'd1) && !force_y0) ? 8'd168 : 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [2:0] e;
    if (trace_q.size() > 0) begin
      e = trace_q.pop_front();
      check("trace_a_b_done", {29'd0, a, b, done}, {29'd0, e});
    end
  end

  // tr holds n entries of {a,b,done}, first cycle after acceptance in the
  // most significant used position.
  task automatic issue(input logic [1:0] t, input logic [7:0] h, input int n, input logic [23:0] tr);
    @(negedge clk);
    check("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    cmd_valid  = 1'b1;
    cmd_target = t;
    cmd_hold   = h;
    @(posedge clk);
    for (int i = 0; i < n; i++) trace_q.push_back(tr[3*(n-1-i) +: 3]);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (trace_q.size() > 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk);
    check("trace_drained_in_budget", trace_q.size(), 32'd0);
    trace_q.delete();
  endtask

  initial begin
    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_a", {31'd0, a}, 32'd0);
    check("rst_b", {31'd0, b}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);

    // S0 -> S2, hold 5 (forced to 0)
    issue(2'd2, 8'd5, 3, 24'b110_001_000);
    wait_drain();
    check("s2_returns_to_s0", {30'd0, fsm_s}, 32'd0);
    // S0 -> S1, hold 3
    issue(2'd1, 8'd3, 6, 24'b100_000_000_000_001_000);
    wait_drain();
    // S1 -> S2, hold 0: routed via S0
    issue(2'd2, 8'd0, 4, 24'b100_110_001_000);
    wait_drain();
    // Target 3 means S0, already there: straight to dwell
    issue(2'd3, 8'd2, 4, 24'b000_000_001_000);
    wait_drain();
    // Already in target with zero hold: done next cycle
    issue(2'd0, 8'd0, 2, 24'b001_000);
    wait_drain();

    // Back-to-back: S0->S1 hold 0, then S1->S0 hold 1 accepted in DONE
    issue(2'd1, 8'd0, 6, 24'b100_001_100_000_001_000);
    @(posedge clk);
    @(negedge clk);
    check("b2b_ready_in_done", {31'd0, cmd_ready}, 32'd1);
    cmd_valid  = 1'b1;
    cmd_target = 2'd0;
    cmd_hold   = 8'd1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_drain();
    check("clean_err", {31'd0, err}, 32'd0);
    check("clean_err_cnt", {24'd0, err_cnt}, 32'd0);

    // Park in S1, then corrupt y for one cycle
    issue(2'd1, 8'd0, 3, 24'b100_001_000);
    wait_drain();
    @(negedge clk);
    force_y0 = 1'b1;
    @(negedge clk);
    force_y0 = 1'b0;
    check("fault_err", {31'd0, err}, CHK ? 32'd1 : 32'd0);
    check("fault_err_cnt", {24'd0, err_cnt}, CHK ? 32'd1 : 32'd0);

    // 300 consecutive mismatches saturate the count
    corrupt_x = 1'b1;
    repeat (300) @(negedge clk);
    corrupt_x = 1'b0;
    check("sat_err_cnt", {24'd0, err_cnt}, CHK ? 32'd255 : 32'd0);
    check("sat_err", {31'd0, err}, CHK ? 32'd1 : 32'd0);

    // Reset in cycle 1 of S1 -> S2
    issue(2'd2, 8'd0, 3, 24'b100_000_000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("midrst_err", {31'd0, err}, 32'd0);
    check("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
    wait_drain();
    issue(2'd1, 8'd0, 3, 24'b100_001_000);
    wait_drain();
    check("post_rst_err", {31'd0, err}, 32'd0);
    check("post_rst_err_cnt", {24'd0, err_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fsm_eg_driver.md
# fsm_eg_driver

Stimulus driver and checker for the tutorial three-state `fsm_eg` machine (inputs `a`/`b`; Mealy output `x`, Moore output `y`). It accepts "go to state N and dwell H cycles" commands over a valid/ready handshake. It steers the machine by generating `a`/`b`, keeps a shadow copy of the machine's state, and checks the machine's `x`/`y` every cycle against the shadow model. It sits beside the FSM under test in the Zybo tutorial designs and is driven from a PS-side register block.

## Interface
- `HOLD_W`, 8: width of the dwell count.
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset. The FSM under test must receive `rst_n = ~rst`.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: driver can accept a command.
- `cmd_target` in 2: target state. 0 = S0, 1 = S1, 2 = S2; 3 is treated as S0.
- `cmd_hold` in HOLD_W: dwell cycles in the target after arrival.
- `done` out 1: one-cycle pulse when the command completes.
- `a`, `b` out 1: registered drive to the FSM under test.
- `x`, `y` in 8: outputs of the FSM under test.
- `err` out 1: sticky mismatch flag.
- `err_cnt` out 8: saturating mismatch count.

## Operation
- **Shadow state.** The shadow state follows the FSM rules exactly:
  - S0: `a&b` → S2, `a&~b` → S1, else stays S0.
  - S1: `a` → S0, else stays S1.
  - S2: → S0 unconditionally.
- **Expected outputs.**
  - `x_exp` = 168 if the shadow state is S0 or S2 and `a&b`, else 0.
  - `y_exp` = 168 if the shadow state is S1, else 0.
- **Control states.**
  - IDLE: `cmd_ready=1`, `a=b=0`.
  - STEER: one drive cycle per step.
  - DWELL: `a=b=0`, counting down the hold.
  - DONE: `done=1`, `cmd_ready=1`, `a=b=0`.
  - A handshake in IDLE or DONE latches the target and hold, then moves to STEER. If the shadow state already equals the target, it moves straight to DWELL, or to DONE when the hold is 0.
  - Without a handshake, DONE → IDLE.
- **Steering drive, one cycle each:**
  - S0→S1: `a=1, b=0`.
  - S0→S2: `a=1, b=1`.
  - S1→S0: `a=1, b=0`.
  - S2→any: `a=0, b=0` (lands in S0).
  - S1→S2 runs S1→S0 and then S0→S2.
  - S2→S1 runs S2→S0 and then S0→S1.
  - STEER ends when the shadow state equals the target. It then goes to DWELL if the hold is nonzero, else to DONE.
- **Dwell.**
  - The dwell length equals `cmd_hold`.
  - For target S2 the hold is forced to 0, because S2 cannot dwell.
  - In DONE with target S2, the FSM is in S2. It moves to S0 at the end of that cycle.
- **Checker.**
  - Runs every cycle outside reset, in all control states.
  - A mismatch is `x != x_exp` or `y != y_exp`. It counts once per cycle.
  - On a mismatch `err` is set (it clears only on `rst`) and `err_cnt` increments, saturating at 255.
- **Reset.** `rst` at any point, including mid-STEER or mid-DWELL, forces:
  - IDLE, shadow state = S0, `a=b=0`, `done=0`;
  - `cmd_ready=1`, `err=0`, `err_cnt=0`.

## Timing
- Let `k` be the clock edge where the command is accepted. Cycles are numbered from `k`.
- The first steering drive appears in cycle `k+1`.
- The FSM and the shadow state update on the same edge.
- `done` is high in cycle `k+1+steps+hold`, where steps is 0, 1 or 2.
- Back-to-back commands: a new command accepted during DONE starts steering in the next cycle, with no idle gap.
- `x`/`y` are compared in the same cycle as the `a`/`b` that produced them. The FSM under test is combinational from `a`/`b` to `x`.
- Reset values:
  - `cmd_ready=1`;
  - `done=0`, `a=0`, `b=0`;
  - `err=0`, `err_cnt=0`.

## Configuration
- `FSM_EG_DRV_CHECK_EN` defined: the checker is built as described.
- Not defined:
  - `x`/`y` are ignored;
  - `err` and `err_cnt` are tied to 0;
  - ports and steering behaviour are unchanged.

## Structure
- Package `fsm_eg_pkg` holds:
  - the S0/S1/S2 encodings, 2 bits;
  - the output constant 168;
  - the driver control-state encodings.
- Sub-module `fsm_eg_model` is combinational. It takes the shadow state and `a`/`b` and returns the next state, `x_exp` and `y_exp`.

## Test plan
- **Reset.** Assert `rst` for 2 cycles → `cmd_ready=1`, `a=b=0`, `done=0`, `err=0`, `err_cnt=0`.
- **S0 → S2, hold 5, accepted at edge 0.**
  - Cycle 1: `a=b=1`, `x=168`.
  - Cycle 2: `done=1`.
  - Cycle 3: FSM in S0.
  - `err=0` throughout.
- **S0 → S1, hold 3, accepted at edge 0.**
  - Cycle 1: `a=1, b=0`.
  - Cycles 2–5: `y=168`.
  - `done` in cycle 5.
- **From S1 → S2, hold 0.**
  - Cycle 1: `a=1, b=0`.
  - Cycle 2: `a=b=1`, `x=168`.
  - `done` in cycle 3.
- **Fault injection.**
  - Force `y=0` for one cycle while the shadow state is S1 → `err=1`, `err_cnt=1`.
  - Force 300 consecutive mismatches → `err_cnt=255`.
- **Reset mid-operation.** Assert `rst` in cycle 1 of an S1 → S2 command → IDLE next cycle, no `done`. A following S0 → S1 command completes with `err=0`.
